// File: rtl/pn_generator_param.sv
`default_nettype none
// ============================================================================
// Module   : pn_generator_param
// Purpose  : Fibonacci LFSR PN source, OUT_BITS bits per advance, valid/ready out
// Revision : 1.0
// ============================================================================
module pn_generator_param #(
    parameter int unsigned       WIDTH    = 4,
    parameter logic [WIDTH-1:0]  TAPS     = 4'b0011,
    parameter logic [WIDTH-1:0]  SEED     = 4'b1011,
    parameter int unsigned       OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed_in,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                epoch,
    output logic                seed_err,
    output logic [WIDTH-1:0]    state_out
);

    logic [WIDTH-1:0]    state_q,     state_d;
    logic [WIDTH-1:0]    start_q,     start_d;
    logic [OUT_BITS-1:0] out_data_q,  out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                epoch_q,     epoch_d;
    logic                seed_err_q,  seed_err_d;

    logic [WIDTH-1:0]    adv_state;
    logic [OUT_BITS-1:0] adv_word;
    logic                advance;
    logic                seed_zero;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {^(s & TAPS), s[WIDTH-1:1]};
    endfunction

    // OUT_BITS serial steps unrolled; word bit k is the bit shifted out by step k.
    always_comb begin
        adv_state = state_q;
        adv_word  = '0;
        for (int k = 0; k < OUT_BITS; k++) begin
            adv_word[k] = adv_state[0];
            adv_state   = lfsr_step(adv_state);
        end
    end

    assign advance   = en && !load && (!out_valid_q || out_ready);
    assign seed_zero = (seed_in == '0);

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        epoch_d     = 1'b0;
        seed_err_d  = seed_err_q;

        if (load) begin
            // A load flushes any pending word, even one being accepted this cycle.
            out_valid_d = 1'b0;
            if (seed_zero) begin
                state_d    = SEED;
                start_d    = SEED;
                seed_err_d = 1'b1;
            end else begin
                state_d    = seed_in;
                start_d    = seed_in;
                seed_err_d = 1'b0;
            end
        end else if (advance) begin
            state_d     = adv_state;
            out_data_d  = adv_word;
            out_valid_d = 1'b1;
            epoch_d     = (adv_state == start_q);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEED;
            start_q     <= SEED;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            epoch_q     <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            epoch_q     <= epoch_d;
            seed_err_q  <= seed_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign epoch     = epoch_q;
    assign seed_err  = seed_err_q;
    assign state_out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pn_generator_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_pn_generator_param
// Purpose  : Directed self-checking bench for pn_generator_param (1- and 4-bit words)
// Revision : 1.0
// ============================================================================
module tb_pn_generator_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] seed_in;
    logic       out_ready;

    logic [0:0] out_data1;
    logic       out_valid1, epoch1, seed_err1;
    logic [3:0] state1;

    logic [3:0] out_data4;
    logic       out_valid4, epoch4, seed_err4;
    logic [3:0] state4;

    int n_checks;
    int n_errors;

    // Word 1 sits in bit 0.
    localparam logic [14:0] C_SEQ_DEFAULT = 15'b001000111101011;
    localparam logic [14:0] C_SEQ_SEED9   = 15'b000111101011001;

    pn_generator_param #(.OUT_BITS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .seed_in   (seed_in),
        .out_data  (out_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .epoch     (epoch1),
        .seed_err  (seed_err1),
        .state_out (state1)
    );

    pn_generator_param #(.OUT_BITS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .seed_in   (seed_in),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .epoch     (epoch4),
        .seed_err  (seed_err4),
        .state_out (state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [14:0] seq;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        seed_in   = 4'h0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_valid",    32'(out_valid1), 32'd0);
        chk("rst_data",     32'(out_data1),  32'd0);
        chk("rst_state",    32'(state1),     32'hB);
        chk("rst_epoch",    32'(epoch1),     32'd0);
        chk("rst_seed_err", 32'(seed_err1),  32'd0);

        // Default serial sequence and 4-bit parallel words from the same run
        rst_n     = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        seq       = C_SEQ_DEFAULT;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("ser_data",   32'(out_data1),  32'(seq[0]));
            chk("ser_valid",  32'(out_valid1), 32'd1);
            chk("ser_epoch",  32'(epoch1),     32'(k == 15));
            chk("par_epoch",  32'(epoch4),     32'(k == 15));
            if (k == 1) begin
                chk("par_word1",  32'(out_data4), 32'hB);
                chk("par_state1", 32'(state4),    32'hE);
            end
            if (k == 2)
                chk("par_word2", 32'(out_data4), 32'hE);
            seq = seq >> 1;
        end
        chk("ser_state_wrap", 32'(state1), 32'hB);

        // Backpressure after word 2
        pulse_reset();
        tick();
        tick();
        chk("bp_word2", 32'(out_data1), 32'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data",  32'(out_data1),  32'd1);
            chk("bp_hold_valid", 32'(out_valid1), 32'd1);
            chk("bp_hold_state", 32'(state1),     32'hA);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_w3", 32'(out_data1), 32'd0);
        tick();
        chk("bp_rel_w4", 32'(out_data1), 32'd1);
        tick();
        chk("bp_rel_w5", 32'(out_data1), 32'd0);

        // Seed load while a word is pending and being accepted
        load    = 1'b1;
        seed_in = 4'h9;
        tick();
        chk("ld_valid", 32'(out_valid1), 32'd0);
        chk("ld_state", 32'(state1),     32'h9);
        chk("ld_epoch", 32'(epoch1),     32'd0);
        load = 1'b0;
        seq  = C_SEQ_SEED9;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("ld_data",  32'(out_data1), 32'(seq[0]));
            chk("ld_epoch", 32'(epoch1),    32'(k == 15));
            seq = seq >> 1;
        end

        // Zero seed substitutes SEED and sets the sticky flag
        load    = 1'b1;
        seed_in = 4'h0;
        tick();
        chk("zs_err",   32'(seed_err1),  32'd1);
        chk("zs_state", 32'(state1),     32'hB);
        chk("zs_valid", 32'(out_valid1), 32'd0);
        seed_in = 4'h3;
        tick();
        chk("zs_clear", 32'(seed_err1), 32'd0);
        chk("zs_state3", 32'(state1),   32'h3);

        // Consume without refill
        load = 1'b0;
        tick();
        chk("cw_word",  32'(out_data1), 32'd1);
        chk("cw_state", 32'(state1),    32'h1);
        en = 1'b0;
        tick();
        chk("cw_valid", 32'(out_valid1), 32'd0);
        chk("cw_data",  32'(out_data1),  32'd1);
        chk("cw_state_hold", 32'(state1), 32'h1);

        // Async reset between edges while epoch and seed_err are set
        load    = 1'b1;
        seed_in = 4'h0;
        tick();
        load = 1'b0;
        en   = 1'b1;
        for (int k = 1; k <= 15; k++)
            tick();
        chk("ar_pre_epoch", 32'(epoch1),    32'd1);
        chk("ar_pre_err",   32'(seed_err1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid1), 32'd0);
        chk("ar_epoch", 32'(epoch1),     32'd0);
        chk("ar_err",   32'(seed_err1),  32'd0);
        chk("ar_state", 32'(state1),     32'hB);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
